// File: rtl/boot_sequencer.sv
// Program-load and run controller: streams an image into instruction memory, holds core reset,
// runs the core for RUN_CYCLES and freezes it. Define BOOT_SEQ_TRACE_EN to build the PC trace port.
module boot_sequencer #(
  parameter int DATA_W     = 18,
  parameter int ADDR_W     = 8,
  parameter int RESET_HOLD = 5,
  parameter int RUN_CYCLES = 10000,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] instr_in,
  output logic              trace_valid,
  output logic [ADDR_W-1:0] trace_pc,
  output logic [DATA_W-1:0] trace_instr,
  output logic [CNT_W-1:0]  trace_cycle,
  output logic              overflow,
  output logic              done
);

  typedef enum logic [1:0] {LOAD, HOLD, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  generate
    if (RESET_HOLD < 1 || RUN_CYCLES < 1 ||
        (CNT_W < 31 && RUN_CYCLES > (1 << CNT_W) - 1)) begin : g_param_err
      $error("boot_sequencer: RESET_HOLD/RUN_CYCLES must be >=1 and fit in CNT_W");
    end
  endgenerate

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic              arm;
  logic              accept, at_top, load_end;

  // arm keeps load_ready low for the first LOAD cycle after reset or restart
  assign load_ready = (state == LOAD) && arm && !restart && !reset;
  assign accept     = load_valid && load_ready;
  assign at_top     = (addr == ADDR_MAX);
  assign load_end   = accept && (load_last || at_top);
  assign cpu_reset  = (state != RUN);
  assign done       = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (load_end) state_nx = HOLD;
      HOLD:    if (cnt == HOLD_LAST) state_nx = RUN;
      RUN:     if (cnt == RUN_LAST) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = LOAD;
    endcase
    if (restart) state_nx = LOAD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      addr       <= '0;
      cnt        <= '0;
      arm        <= 1'b0;
      overflow   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state   <= state_nx;
      arm     <= !restart;
      imem_we <= accept;
      if (accept) begin
        imem_addr  <= addr;
        imem_wdata <= load_data;
      end
      if (restart) begin
        addr     <= '0;
        cnt      <= '0;
        overflow <= 1'b0;
      end else begin
        if (accept && !at_top) addr <= addr + 1'b1;
        if (load_end) overflow <= !load_last;
        // one counter serves HOLD and RUN; it restarts at every phase change
        if (state_nx != state) cnt <= '0;
        else if (state == HOLD || state == RUN) cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef BOOT_SEQ_TRACE_EN
  logic [ADDR_W-1:0] last_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_instr <= '0;
      trace_cycle <= '0;
      last_pc     <= '0;
    end else begin
      trace_valid <= 1'b0;
      if (!restart && state == RUN && (cnt == '0 || pc_in != last_pc)) begin
        trace_valid <= 1'b1;
        trace_pc    <= pc_in;
        trace_instr <= instr_in;
        trace_cycle <= cnt;
        last_pc     <= pc_in;
      end
    end
  end
`else
  logic unused_trace_in;
  assign unused_trace_in = ^{pc_in, instr_in};
  assign trace_valid     = 1'b0;
  assign trace_pc        = '0;
  assign trace_instr     = '0;
  assign trace_cycle     = '0;
`endif

endmodule
